fixed_mac_accumulator: RTL and testbench

- Streaming signed fixed-point multiply-accumulate for the perceptron datapath. Successor to the single-cycle fixed-point adder.
- Accepts one (a, b) pair per cycle and accumulates the products a*b over a vector delimited by in_last_i.
- Emits one saturated weighted sum per vector, with a valid/ready handshake on both sides.
- Number format is identical to the adder's: two's complement, W = sign + q_m + q_n bits, q_n fraction bits.

---
 rtl/fixed_mac_accumulator.sv | 150 +++++++++++++++
 tb/tb_fixed_mac_accumulator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fixed_mac_accumulator.sv
// Streaming signed fixed-point multiply-accumulate: one (a, b) beat per cycle,
// one saturated sum per in_last_i-delimited vector, valid/ready on both sides.
module fixed_mac_accumulator #(
  parameter int unsigned sign  = 1,
  parameter int unsigned q_m   = 16,
  parameter int unsigned q_n   = 16,
  parameter int unsigned GUARD = 8,
  parameter int unsigned CNT_W = 10,
  localparam int unsigned W    = sign + q_m + q_n
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic [W-1:0]     y_out,
  output logic             ovf_o,
  output logic [CNT_W-1:0] count_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int unsigned AccW = W + GUARD;
  localparam int unsigned PW   = 2 * W;
  localparam logic [AccW-1:0]  AccMax = {1'b0, {(AccW - 1){1'b1}}};
  localparam logic [AccW-1:0]  AccMin = {1'b1, {(AccW - 1){1'b0}}};
  localparam logic [W-1:0]     YMax   = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]     YMin   = {1'b1, {(W - 1){1'b0}}};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StAccum, StFlush, StOutput} state_e;

  state_e state_q, state_d;

  logic            in_valid_q, in_last_q;
  logic [W-1:0]    a_q, b_q;
  logic            s1_valid_q, s1_last_q, s1_ovf_q;
  logic [AccW-1:0] s1_p_q, s1_p_d;
  logic            s1_ovf_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic            ovf_sticky_q, ovf_sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]    y_q, y_d;
  logic            ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;

  logic                   accept;
  logic signed [PW-1:0]   prod, prod_sh;
  logic [AccW:0]          sum;
  logic [AccW-1:0]        acc_next;
  logic                   acc_clamp, y_clamp;
  logic [W-1:0]           y_sat;
  logic [CNT_W-1:0]       cnt_inc;

  assign in_ready_o  = (state_q == StAccum);
  assign out_valid_o = (state_q == StOutput);
  assign accept      = in_valid_i && in_ready_o;
  assign y_out       = y_q;
  assign ovf_o       = ovf_q;
  assign count_o     = cnt_out_q;

  always_comb begin
    // Low 2W bits of the product of sign-extended operands equal the signed product.
    prod    = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};
    prod_sh = prod >>> q_n;
    s1_ovf_d = !((&prod_sh[PW-1:AccW-1]) || !(|prod_sh[PW-1:AccW-1]));
    s1_p_d   = s1_ovf_d ? (prod_sh[PW-1] ? AccMin : AccMax) : prod_sh[AccW-1:0];

    sum       = {acc_q[AccW-1], acc_q} + {s1_p_q[AccW-1], s1_p_q};
    acc_clamp = (sum[AccW] != sum[AccW-1]);
    acc_next  = acc_clamp ? (sum[AccW] ? AccMin : AccMax) : sum[AccW-1:0];
    y_clamp   = !((&acc_next[AccW-1:W-1]) || !(|acc_next[AccW-1:W-1]));
    y_sat     = y_clamp ? (acc_next[AccW-1] ? YMin : YMax) : acc_next[W-1:0];
    cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    acc_d        = acc_q;
    ovf_sticky_d = ovf_sticky_q;
    cnt_d        = cnt_q;
    y_d          = y_q;
    ovf_d        = ovf_q;
    cnt_out_d    = cnt_out_q;
    if (s1_valid_q) begin
      if (s1_last_q) begin
        y_d          = y_sat;
        ovf_d        = ovf_sticky_q || s1_ovf_q || acc_clamp || y_clamp;
        cnt_out_d    = cnt_inc;
        acc_d        = '0;
        ovf_sticky_d = 1'b0;
        cnt_d        = '0;
      end else begin
        acc_d        = acc_next;
        ovf_sticky_d = ovf_sticky_q || s1_ovf_q || acc_clamp;
        cnt_d        = cnt_inc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum:  if (accept && in_last_i) state_d = StFlush;
      StFlush:  if (s1_valid_q && s1_last_q) state_d = StOutput;
      StOutput: if (out_ready_i) state_d = StAccum;
      default:  state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StAccum;
      in_valid_q   <= 1'b0;
      in_last_q    <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_ovf_q     <= 1'b0;
      s1_p_q       <= '0;
      acc_q        <= '0;
      ovf_sticky_q <= 1'b0;
      cnt_q        <= '0;
      y_q          <= '0;
      ovf_q        <= 1'b0;
      cnt_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      in_valid_q   <= accept;
      in_last_q    <= accept && in_last_i;
      if (accept) begin
        a_q <= a_in;
        b_q <= b_in;
      end
      s1_valid_q   <= in_valid_q;
      s1_last_q    <= in_last_q;
      s1_ovf_q     <= s1_ovf_d;
      s1_p_q       <= s1_p_d;
      acc_q        <= acc_d;
      ovf_sticky_q <= ovf_sticky_d;
      cnt_q        <= cnt_d;
      y_q          <= y_d;
      ovf_q        <= ovf_d;
      cnt_out_q    <= cnt_out_d;
    end
  end

endmodule

// File: tb/tb_fixed_mac_accumulator.sv
// Directed bench for fixed_mac_accumulator (Q16.16, W=33) with hand-computed results.
module tb_fixed_mac_accumulator;

  localparam int unsigned W     = 33;
  localparam int unsigned CNT_W = 10;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [W-1:0]     a_in = '0;
  logic [W-1:0]     b_in = '0;
  logic             in_valid_i = 1'b0;
  logic             in_last_i = 1'b0;
  logic             in_ready_o;
  logic [W-1:0]     y_out;
  logic             ovf_o;
  logic [CNT_W-1:0] count_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  fixed_mac_accumulator dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .a_in        (a_in),
    .b_in        (b_in),
    .in_valid_i  (in_valid_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .y_out       (y_out),
    .ovf_o       (ovf_o),
    .count_o     (count_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one beat; it is accepted at the next edge when in_ready_o is high.
  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    a_in       = a;
    b_in       = b;
    in_last_i  = last;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  // Called just after the last beat's edge T: result must appear exactly after T+2.
  task automatic expect_result(input string tag, input logic [W-1:0] ey, input logic eovf,
                               input logic [CNT_W-1:0] ecnt);
    chk({tag, " valid@T"}, 64'(out_valid_o), 64'd0);
    step();
    chk({tag, " valid@T+1"}, 64'(out_valid_o), 64'd0);
    step();
    chk({tag, " valid@T+2"}, 64'(out_valid_o), 64'd1);
    chk({tag, " y"}, 64'(y_out), 64'(ey));
    chk({tag, " ovf"}, 64'(ovf_o), 64'(eovf));
    chk({tag, " count"}, 64'(count_o), 64'(ecnt));
    chk({tag, " ready_low"}, 64'(in_ready_o), 64'd0);
    if (out_ready_i) begin
      step();
      chk({tag, " valid_clr"}, 64'(out_valid_o), 64'd0);
      chk({tag, " ready_back"}, 64'(in_ready_o), 64'd1);
    end
  endtask

  initial begin
    #1;
    chk("rst y", 64'(y_out), 64'd0);
    chk("rst ovf", 64'(ovf_o), 64'd0);
    chk("rst count", 64'(count_o), 64'd0);
    chk("rst valid", 64'(out_valid_o), 64'd0);
    chk("rst ready", 64'(in_ready_o), 64'd1);
    #13 rst_ni = 1'b1;
    step();

    // 1.5*2.0 + (-1.0)*0.5 = 2.5
    beat(33'h18000, 33'h20000, 1'b0);
    beat(-33'sd65536, 33'h08000, 1'b1);
    expect_result("basic", 33'h28000, 1'b0, 10'd2);

    // Arithmetic shift truncates toward minus infinity
    beat(33'd1, 33'd1, 1'b1);
    expect_result("trunc_pos", 33'h0, 1'b0, 10'd1);
    beat(-33'sd1, 33'd1, 1'b1);
    expect_result("trunc_neg", 33'h1_FFFF_FFFF, 1'b0, 10'd1);

    // 2^32 clamps to the W max; -2^32 is exactly the W min, so nothing clamps there
    beat(33'h100_0000, 33'h100_0000, 1'b1);
    expect_result("sat_pos", 33'h0_FFFF_FFFF, 1'b1, 10'd1);
    beat(-33'sh100_0000, 33'h100_0000, 1'b1);
    expect_result("sat_neg", 33'h1_0000_0000, 1'b0, 10'd1);
    beat(33'h8000, 33'h8000, 1'b1);
    expect_result("sticky_clr", 33'h4000, 1'b0, 10'd1);

    // Back-pressure with beats offered during the stall
    out_ready_i = 1'b0;
    beat(33'h10000, 33'h10000, 1'b1);
    expect_result("bp", 33'h10000, 1'b0, 10'd1);
    a_in       = 33'h70000;
    b_in       = 33'h10000;
    in_last_i  = 1'b1;
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp hold valid", 64'(out_valid_o), 64'd1);
      chk("bp hold y", 64'(y_out), 64'h10000);
      chk("bp hold count", 64'(count_o), 64'd1);
      chk("bp hold ready", 64'(in_ready_o), 64'd0);
    end
    in_valid_i  = 1'b0;
    in_last_i   = 1'b0;
    out_ready_i = 1'b1;
    step();
    chk("bp release valid", 64'(out_valid_o), 64'd0);
    chk("bp retain y", 64'(y_out), 64'h10000);
    beat(33'h10000, 33'h30000, 1'b1);
    expect_result("bp next", 33'h30000, 1'b0, 10'd1);

    // Five back-to-back beats of 1.0*1.0
    for (int i = 0; i < 5; i++) begin
      chk("stream ready", 64'(in_ready_o), 64'd1);
      beat(33'h10000, 33'h10000, (i == 4));
    end
    expect_result("stream", 33'h50000, 1'b0, 10'd5);

    // Asynchronous reset between edges, mid-vector
    beat(33'h10000, 33'h10000, 1'b0);
    beat(33'h10000, 33'h10000, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst y", 64'(y_out), 64'd0);
    chk("midrst ovf", 64'(ovf_o), 64'd0);
    chk("midrst count", 64'(count_o), 64'd0);
    chk("midrst valid", 64'(out_valid_o), 64'd0);
    chk("midrst ready", 64'(in_ready_o), 64'd1);
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst no output", 64'(out_valid_o), 64'd0);
    end
    beat(33'h20000, 33'h10000, 1'b1);
    expect_result("post_rst", 33'h20000, 1'b0, 10'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
